// File: rtl/instr_seq_ctrl_pkg.sv
// Shared types and constants for the instruction sequencer controller.
// The optional single-step feature is enabled by defining INSTR_SEQ_STEP_EN.
package instr_seq_ctrl_pkg;

   // Controller states, binary encoded
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_EXEC  = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERROR = 3'd5
   } seq_state_t;

   // ROM read latency covered by the FETCH state (cycles)
   localparam int FETCH_LAT = 1;

   // Width of the completed-instruction counter
   localparam int COUNT_W = 16;

   // True for the states in which an instruction is in flight
   function automatic logic is_active(input seq_state_t s);
      return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_EXEC);
   endfunction

endpackage

// File: rtl/instr_seq_ctrl_watchdog.sv
// EXEC-phase watchdog: counts cycles spent in EXEC and flags expiry when the
// TIMEOUT-th EXEC cycle is reached without the instruction completing.
module seq_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_r;

   // Cycle counter: cleared before EXEC entry, saturates at the limit
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable && (count_r != LIMIT)) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Expiry is only meaningful while the controller sits in EXEC
   assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer controller: walks a synchronous instruction ROM,
// strobes the processor, counts completed instructions and halts or traps.
// Optional single-step input Step is present when INSTR_SEQ_STEP_EN is defined.
module instr_seq_ctrl
   import instr_seq_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 64,
   parameter int WRAP    = 1
) (
   input  logic               Clock,
   input  logic               Reset,
`ifdef INSTR_SEQ_STEP_EN
   input  logic               Step,
`endif
   input  logic               Start,
   input  logic               Stop,
   input  logic               Done,
   input  logic               Incr,
   output logic [ADDR_W-1:0]  Addr,
   output logic               Run,
   output logic               Busy,
   output logic               Halted,
   output logic               Error,
   output logic [COUNT_W-1:0] InstrCount
);

   localparam logic WRAP_EN = (WRAP != 0);

   seq_state_t state_r;
   logic       stop_r;
   logic       step_s;
   logic       wd_clear_s;
   logic       wd_enable_s;
   logic       wd_expired_s;
   logic       last_addr_s;
   logic       halt_s;

`ifdef INSTR_SEQ_STEP_EN
   assign step_s = Step;
`else
   assign step_s = 1'b0;
`endif

   // Watchdog restarts while issuing so it reads zero on the first EXEC cycle
   assign wd_clear_s  = (state_r == ST_ISSUE);
   assign wd_enable_s = (state_r == ST_EXEC);

   // A Stop arriving together with Done still counts for this boundary
   assign last_addr_s = (Addr == {ADDR_W{1'b1}});
   assign halt_s      = stop_r | Stop | step_s | (~WRAP_EN & last_addr_s);

   seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .Clock   (Clock),
      .Reset   (Reset),
      .clear   (wd_clear_s),
      .enable  (wd_enable_s),
      .expired (wd_expired_s)
   );

   // Sequencer FSM with registered status outputs and stop latch
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         Addr       <= {ADDR_W{1'b0}};
         InstrCount <= {COUNT_W{1'b0}};
         stop_r     <= 1'b0;
         Run        <= 1'b0;
         Busy       <= 1'b0;
         Halted     <= 1'b0;
         Error      <= 1'b0;
      end else begin
         // Stop is only remembered while an instruction is in flight
         stop_r <= stop_r | (Stop & is_active(state_r));
         Run    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  state_r <= ST_FETCH;
                  Busy    <= 1'b1;
               end
            end
            ST_FETCH: begin
               state_r <= ST_ISSUE;
               Run     <= 1'b1;
            end
            ST_ISSUE: begin
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               if (Done) begin
                  Addr       <= Addr + ADDR_W'(1);
                  InstrCount <= InstrCount + COUNT_W'(1);
                  if (halt_s) begin
                     state_r <= ST_HALT;
                     Busy    <= 1'b0;
                     Halted  <= 1'b1;
                     stop_r  <= 1'b0;
                  end else begin
                     state_r <= ST_FETCH;
                  end
               end else if (wd_expired_s) begin
                  state_r <= ST_ERROR;
                  Busy    <= 1'b0;
                  Error   <= 1'b1;
               end else if (Incr) begin
                  Addr <= Addr + ADDR_W'(1);
               end
            end
            ST_HALT: begin
               if (Start) begin
                  state_r <= ST_FETCH;
                  Busy    <= 1'b1;
                  Halted  <= 1'b0;
                  stop_r  <= 1'b0;
               end
            end
            ST_ERROR: begin
               state_r <= ST_ERROR;
            end
            default: begin
               state_r <= ST_ERROR;
               Busy    <= 1'b0;
               Halted  <= 1'b0;
               Error   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios plus randomized
// instruction streams compared against a transaction-level reference model.
module tb_instr_seq_ctrl;
   import instr_seq_ctrl_pkg::*;

   localparam int AW = 5;
   localparam int TO = 64;

   logic Clock = 1'b0;
   logic Reset, Start, Stop, Done, Incr;
`ifdef INSTR_SEQ_STEP_EN
   logic Step;
`endif
   logic [AW-1:0] Addr, addr_nw;
   logic          Run, Busy, Halted, Error;
   logic          run_nw, busy_nw, halted_nw, error_nw;
   logic [15:0]   InstrCount, count_nw;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  m_addr;
   int  m_count;
   bit  m_step  = 1'b0;

   instr_seq_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .WRAP(1)) dut (
      .Clock(Clock), .Reset(Reset),
`ifdef INSTR_SEQ_STEP_EN
      .Step(Step),
`endif
      .Start(Start), .Stop(Stop), .Done(Done), .Incr(Incr),
      .Addr(Addr), .Run(Run), .Busy(Busy), .Halted(Halted), .Error(Error),
      .InstrCount(InstrCount)
   );

   instr_seq_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .WRAP(0)) dut_nw (
      .Clock(Clock), .Reset(Reset),
`ifdef INSTR_SEQ_STEP_EN
      .Step(Step),
`endif
      .Start(Start), .Stop(Stop), .Done(Done), .Incr(Incr),
      .Addr(addr_nw), .Run(run_nw), .Busy(busy_nw), .Halted(halted_nw),
      .Error(error_nw), .InstrCount(count_nw)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset(input bit check_state);
      Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Done = 1'b0; Incr = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      m_addr  = 0;
      m_count = 0;
      tick();
      if (check_state) begin
         check_eq("rst_addr",   Addr,       0);
         check_eq("rst_run",    Run,        0);
         check_eq("rst_busy",   Busy,       0);
         check_eq("rst_halted", Halted,     0);
         check_eq("rst_error",  Error,      0);
         check_eq("rst_count",  InstrCount, 0);
      end
   endtask

   // Start pulse from IDLE or HALT; ends with the Run strobe observed
   task automatic start_exec();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check_eq("start_busy",   Busy,   1);
      check_eq("start_halted", Halted, 0);
      check_eq("start_run0",   Run,    0);
      repeat (FETCH_LAT) tick();
      check_eq("start_run",  Run,  1);
      check_eq("start_addr", Addr, m_addr);
   endtask

   // One instruction: entered with Run visible, lat EXEC cycles, Done on the last
   task automatic run_instr(input int lat, input logic [63:0] incr_bits,
                            input int stop_cyc, output bit halted);
      bit stop_seen;
      stop_seen = 1'b0;
      Incr = 1'($urandom_range(0, 1));
      Done = 1'b0;
      tick();
      check_eq("run_once", Run, 0);
      for (int c = 0; c < lat; c++) begin
         Incr = incr_bits[c];
         Done = (c == lat - 1);
         Stop = (c == stop_cyc);
         if (Stop) stop_seen = 1'b1;
         tick();
         if (Done || Incr) m_addr = (m_addr + 1) % 32;
         if (Done) m_count = (m_count + 1) % 65536;
      end
      Incr = 1'b0; Done = 1'b0; Stop = 1'b0;
      halted = stop_seen || m_step;
      check_eq("instr_count", InstrCount, m_count);
      check_eq("instr_halt",  Halted,     halted);
      check_eq("instr_addr",  Addr,       m_addr);
      if (!halted) begin
         check_eq("refetch_busy", Busy, 1);
         repeat (FETCH_LAT) tick();
         check_eq("next_run",  Run,  1);
         check_eq("next_addr", Addr, m_addr);
      end else begin
         check_eq("halt_busy", Busy, 0);
      end
   endtask

   initial begin
      bit h;
      int c0;
      int lat;
      int stp;
`ifdef INSTR_SEQ_STEP_EN
      Step = 1'b0;
`endif
      do_reset(1'b1);

      // Basic sequencing: Run at spec cycles 2, 7, 12, addresses 0, 1, 2
      Start = 1'b1;
      tick();
      Start = 1'b0;
      c0 = cyc;
      repeat (FETCH_LAT) tick();
      check_eq("seq_run_cyc0", (Run == 1'b1) ? (cyc - c0 + 1) : 0, 2);
      check_eq("seq_addr0", Addr, 0);
      run_instr(3, 64'd0, -1, h);
      check_eq("seq_run_cyc1", cyc - c0 + 1, 7);
      run_instr(3, 64'd0, -1, h);
      check_eq("seq_run_cyc2", cyc - c0 + 1, 12);
      run_instr(3, 64'd0, -1, h);
      check_eq("seq_count3", InstrCount, 3);

      // Incr at Addr=4 then Done -> Addr=6
      run_instr(2, 64'd0, -1, h);
      check_eq("incr_at4", Addr, 4);
      run_instr(3, 64'd1, -1, h);
      check_eq("incr_done_addr", Addr, 6);
      check_eq("incr_done_cnt", InstrCount, 5);

      // Incr and Done together at Addr=4 -> Addr=5
      do_reset(1'b0);
      start_exec();
      for (int i = 0; i < 4; i++) run_instr(1, 64'd0, -1, h);
      run_instr(1, 64'd1, -1, h);
      check_eq("incr_and_done", Addr, 5);

      // Stop at Addr=7 -> halt with Addr=8, resume keeps count
      run_instr(2, 64'd0, -1, h);
      run_instr(1, 64'd0, -1, h);
      check_eq("stop_at7", Addr, 7);
      run_instr(3, 64'd0, 0, h);
      check_eq("stop_halted", Halted, 1);
      check_eq("stop_addr8",  Addr,   8);
      Stop = 1'b1; tick(); Stop = 1'b0;
      tick();
      check_eq("halt_hold", Halted, 1);
      start_exec();
      check_eq("resume_cnt", InstrCount, m_count);
      run_instr(2, 64'd0, -1, h);
      check_eq("stop_in_halt_ignored", Halted, 0);

      // Stop while idle is not remembered
      do_reset(1'b0);
      Stop = 1'b1; tick(); Stop = 1'b0;
      start_exec();
      run_instr(2, 64'd0, -1, h);
      check_eq("stop_in_idle_ignored", Halted, 0);

      // Wrap: 32 instructions; WRAP=1 reissues at 0, WRAP=0 halts at 0
      do_reset(1'b0);
      start_exec();
      for (int i = 0; i < 32; i++) run_instr(1, 64'd0, -1, h);
      check_eq("wrap_run_at0",   Run,       1);
      check_eq("wrap_addr0",     Addr,      0);
      check_eq("wrap_nohalt",    Halted,    0);
      check_eq("nowrap_halted",  halted_nw, 1);
      check_eq("nowrap_addr0",   addr_nw,   0);
      check_eq("nowrap_count",   count_nw,  32);
      check_eq("nowrap_busy",    busy_nw,   0);

      // Randomized instruction stream, with one Done exactly at the watchdog limit
      do_reset(1'b0);
      start_exec();
      run_instr(TO, 64'd0, -1, h);
      check_eq("done_at_limit_err", Error, 0);
      for (int i = 0; i < 40; i++) begin
         lat = $urandom_range(1, 8);
         stp = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 1) : -1;
         run_instr(lat, {$urandom, $urandom}, stp, h);
         if (h) start_exec();
      end

      // Watchdog: no Done for TO EXEC cycles -> sticky ERROR
      do_reset(1'b0);
      start_exec();
      for (int i = 0; i < 3; i++) run_instr(2, {$urandom, $urandom}, -1, h);
      tick();
      repeat (TO - 1) tick();
      check_eq("wd_last_busy", Busy,  1);
      check_eq("wd_last_err",  Error, 0);
      tick();
      check_eq("wd_error", Error, 1);
      check_eq("wd_busy",  Busy,  0);
      Start = 1'b1; Done = 1'b1; Incr = 1'b1;
      repeat (3) tick();
      Start = 1'b0; Done = 1'b0; Incr = 1'b0;
      check_eq("err_sticky",     Error,      1);
      check_eq("err_run",        Run,        0);
      check_eq("err_addr_frz",   Addr,       m_addr);
      check_eq("err_count_frz",  InstrCount, m_count);
      #2 Reset = 1'b1;
      #1;
      check_eq("err_rst_async",  Error, 0);
      check_eq("err_rst_addr",   Addr,  0);
      tick();
      Reset = 1'b0;

      // Asynchronous reset mid-EXEC at Addr=9, and during the Run strobe
      do_reset(1'b0);
      start_exec();
      for (int i = 0; i < 9; i++) run_instr(1, 64'd0, -1, h);
      check_eq("mid_addr9", Addr, 9);
      tick();
      tick();
      #2 Reset = 1'b1;
      #1;
      check_eq("mid_rst_addr",  Addr,       0);
      check_eq("mid_rst_run",   Run,        0);
      check_eq("mid_rst_busy",  Busy,       0);
      check_eq("mid_rst_count", InstrCount, 0);
      do_reset(1'b0);
      start_exec();
      #2 Reset = 1'b1;
      #1;
      check_eq("issue_rst_run", Run, 0);
      do_reset(1'b0);

`ifdef INSTR_SEQ_STEP_EN
      // Single-step: every Start executes exactly one instruction
      Step   = 1'b1;
      m_step = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_exec();
         run_instr($urandom_range(1, 4), 64'd0, -1, h);
         check_eq("step_halt", Halted, 1);
         check_eq("step_count", InstrCount, i + 1);
      end
      Step   = 1'b0;
      m_step = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
